// File: rtl/data_sram_ctrl_pkg.sv
// Shared encodings for the data SRAM controller: access types, FSM states,
// bus size codes and a one-hot decode of the access type.
package data_sram_ctrl_pkg;

    localparam logic [2:0] TYPE_B  = 3'd0;
    localparam logic [2:0] TYPE_H  = 3'd1;
    localparam logic [2:0] TYPE_W  = 3'd2;
    localparam logic [2:0] TYPE_WL = 3'd3;
    localparam logic [2:0] TYPE_WR = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef struct packed {
        logic b;
        logic h;
        logic w;
        logic wl;
        logic wr;
    } type_dec_t;

    function automatic type_dec_t decode_type(input logic [2:0] t);
        type_dec_t d;
        d.b  = (t == TYPE_B);
        d.h  = (t == TYPE_H);
        d.w  = (t == TYPE_W);
        d.wl = (t == TYPE_WL);
        d.wr = (t == TYPE_WR);
        return d;
    endfunction

endpackage

// File: rtl/data_sram_ctrl_wstrb_gen.sv
// Byte-lane write strobe generator; loads never assert any lane.
module mem_wstrb_gen
    import data_sram_ctrl_pkg::*;
(
    input  logic       is_store,
    input  type_dec_t  dec,
    input  logic [1:0] off,
    output logic [3:0] wstrb
);

    always_comb begin
        wstrb = 4'b0000;
        if (is_store) begin
            if (dec.b) begin
                wstrb = 4'b0001 << off;
            end else if (dec.h) begin
                wstrb = off[1] ? 4'b1100 : 4'b0011;
            end else if (dec.w) begin
                wstrb = 4'b1111;
            end else if (dec.wl) begin
                wstrb = 4'b1111 >> (2'd3 - off);
            end else if (dec.wr) begin
                wstrb = 4'b1111 << off;
            end
        end
    end

endmodule

// File: rtl/data_sram_ctrl.sv
// Single-outstanding data SRAM bus controller between the pipeline memory
// stage and an addr_ok/data_ok style bus.
//
// state | meaning
// IDLE  | no transaction, ready to accept unless flushed
// REQ   | data_req held with stable fields until addr_ok
// WAIT  | address taken, waiting for data_ok
// RESP  | resp_valid held until resp_ready or flush
module data_sram_ctrl
    import data_sram_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    logic [1:0]  state_q, state_d;
    logic        cancel_q, cancel_d;
    logic        data_req_q, data_req_d;
    logic        resp_valid_q, resp_valid_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    type_dec_t   dec;
    logic [1:0]  off;
    logic [3:0]  wstrb_n;
    logic [1:0]  size_n;
    logic [31:0] addr_n;
    logic [31:0] wdata_n;
    logic [4:0]  shamt_l;
    logic [4:0]  shamt_r;
    logic        accept;

    assign dec       = decode_type(req_type);
    assign off       = req_addr[1:0];
    assign req_ready = (state_q == ST_IDLE) & ~flush;
    assign accept    = req_valid & req_ready;

    mem_wstrb_gen u_wstrb (
        .is_store (req_wr),
        .dec      (dec),
        .off      (off),
        .wstrb    (wstrb_n)
    );

    // Unaligned word halves: WL moves the high bytes down, WR moves the low bytes up.
    assign shamt_l = {2'd3 - off, 3'b000};
    assign shamt_r = {off, 3'b000};

    always_comb begin
        size_n  = SIZE_W;
        addr_n  = req_addr;
        wdata_n = req_wdata;
        if (dec.b) begin
            size_n  = SIZE_B;
            wdata_n = {4{req_wdata[7:0]}};
        end else if (dec.h) begin
            size_n  = SIZE_H;
            wdata_n = {2{req_wdata[15:0]}};
        end else if (dec.wl) begin
            addr_n  = {req_addr[31:2], 2'b00};
            wdata_n = req_wdata >> shamt_l;
        end else if (dec.wr) begin
            addr_n  = {req_addr[31:2], 2'b00};
            wdata_n = req_wdata << shamt_r;
        end
    end

    always_comb begin
        state_d      = state_q;
        cancel_d     = cancel_q;
        data_req_d   = data_req_q;
        resp_valid_d = resp_valid_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_REQ;
                    data_req_d = 1'b1;
                    cancel_d   = 1'b0;
                    wr_d       = req_wr;
                    size_d     = size_n;
                    addr_d     = addr_n;
                    wstrb_d    = wstrb_n;
                    wdata_d    = wdata_n;
                end
            end
            ST_REQ: begin
                if (flush) cancel_d = 1'b1;
                if (data_addr_ok) begin
                    state_d    = ST_WAIT;
                    data_req_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (data_data_ok) begin
                    rdata_d  = data_rdata;
                    cancel_d = 1'b0;
                    // A flush landing together with data_ok kills the response too.
                    if (cancel_q | flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                    end
                end else if (flush) begin
                    cancel_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (flush | resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cancel_q     <= 1'b0;
            data_req_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= 32'd0;
            wstrb_q      <= 4'd0;
            wdata_q      <= 32'd0;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            cancel_q     <= cancel_d;
            data_req_q   <= data_req_d;
            resp_valid_q <= resp_valid_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    assign data_req   = data_req_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wstrb = wstrb_q;
    assign data_wdata = wdata_q;

endmodule
